// File: rtl/clk_div_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : clk_div_gen
//  Purpose  : Multi-channel clock-enable / divided-clock generator with a lock
//             sequencer that holds a downstream synchronous reset until the
//             clock tree is considered stable.
//  Ports    : clk      - PLL output clock, all logic on its rising edge
//             reset    - asynchronous active-high reset
//             div      - per-channel divisor, channel i at [i*DIV_WIDTH +: DIV_WIDTH]
//             resync   - one-cycle pulse, phase-aligns all channels
//             ce       - per-channel one-cycle clock-enable strobe
//             clk_div  - per-channel divided square wave (fabric signal)
//             locked   - high once the lock count has elapsed
//             rst_out  - synchronous active-high reset for downstream logic
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_gen #(
  parameter int NUM_CH      = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH*DIV_WIDTH-1:0]   div,
  input  logic                          resync,
  output logic [NUM_CH-1:0]             ce,
  output logic [NUM_CH-1:0]             clk_div,
  output logic                          locked,
  output logic                          rst_out
);

  localparam int                c_lcnt_w   = $clog2(LOCK_CYCLES + 1);
  localparam logic [c_lcnt_w-1:0] c_lock_max = c_lcnt_w'(LOCK_CYCLES);

  // --------------------------------------------------------------------------
  // Divider channels
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_d_act;
    logic [DIV_WIDTH-1:0] w_div;
    logic                 w_bypass;
    logic                 w_wrap;

    assign w_div    = div[i*DIV_WIDTH +: DIV_WIDTH];
    // Divisors 0 and 1 both mean "no division": strobe every cycle.
    assign w_bypass = (r_d_act <= DIV_WIDTH'(1));
    assign w_wrap   = (r_cnt == (r_d_act - DIV_WIDTH'(1)));

    // The divisor is only sampled at a period boundary (or every cycle in
    // bypass), so a running period always finishes with the old divisor and
    // no short pulse can appear on ce/clk_div.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt   <= '0;
        r_d_act <= '0;
      end else if (resync || w_bypass || w_wrap) begin
        r_cnt   <= '0;
        r_d_act <= w_div;
      end else begin
        r_cnt   <= r_cnt + DIV_WIDTH'(1);
      end
    end

    // Outputs decode channel registers only.
    assign ce[i]      = w_bypass | w_wrap;
    assign clk_div[i] = ~w_bypass & (r_cnt < (r_d_act >> 1));
  end : g_ch

  // --------------------------------------------------------------------------
  // Lock sequencer
  // --------------------------------------------------------------------------
  logic [c_lcnt_w-1:0] r_lcnt;
  logic [c_lcnt_w-1:0] w_lcnt_next;
  logic                r_locked;
  logic                r_rst_out;

  assign w_lcnt_next = (r_lcnt == c_lock_max) ? r_lcnt : (r_lcnt + c_lcnt_w'(1));

  // locked and rst_out are registered from the next count so both change on
  // the very edge at which the count reaches LOCK_CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lcnt    <= '0;
      r_locked  <= 1'b0;
      r_rst_out <= 1'b1;
    end else begin
      r_lcnt    <= w_lcnt_next;
      r_locked  <= (w_lcnt_next == c_lock_max);
      r_rst_out <= ~(w_lcnt_next == c_lock_max);
    end
  end

  assign locked  = r_locked;
  assign rst_out = r_rst_out;

endmodule : clk_div_gen
`default_nettype wire
